problem3: RTL and testbench
===========================

// Module: problem3
// PURPOSE
//  - Parameterised 2^N-to-N priority encoder with registered outputs.
//  - Reports the index of the highest-numbered asserted input bit, plus a valid flag.
//  - Used as a generic one-of-many / highest-request index encoder in datapath and arbitration logic.
// PARAMETERS
//  - N  default 2  output index width; input width is 2**N (N >= 1).
// PORTS
//  - clk    input   1       single clock; all state updates on rising edge.
//  - rst_n  input   1       synchronous reset, active-low; sampled on rising clk edge.
//  - in     input   2**N    request vector; bit i set = request i present.
//  - out    output  N       registered index of highest set bit of in.
//  - valid  output  1       registered; 1 when at least one bit of in was set.
// BEHAVIOUR
//  - Reset
//    - Reset is synchronous, active-low, single clock.
//    - On a rising clk edge with rst_n==0: out<=0, valid<=0.
//    - Reset overrides any in value.
//    - Deasserting reset mid-stream: the first edge with rst_n==1 captures the current in normally.
//  - Encoding (combinational, evaluated from in sampled at each rising edge with rst_n==1)
//    - Priority: MSB highest. out = largest i with in[i]==1; all lower bits are ignored.
//    - valid = |in.
//    - in == 0: out <= 0, valid <= 0. This is the only case where valid==0 outside reset.
//    - in == 1: out <= 0, valid <= 1. valid distinguishes this from the all-zero case.
//  - Latency
//    - Exactly 1 clk cycle from in to out/valid.
//    - New result every cycle; no stall, no handshake.
//    - Outputs are held stable between edges.
//  - Width rules
//    - out is exactly N bits and covers indices 0..2**N-1; no overflow possible.
//    - No X propagation: if any bit of in is X, the outputs are don't-care (bench drives only 0/1).
//  - Implementation
//    - Implement for arbitrary N using a loop or generate; no hard-coded case table.
// TESTING (N=2 unless noted)
//  - Reset: rst_n=0 for 2 edges with in=4'b1111 -> out=2'b00, valid=0 after each edge.
//  - All-zero input: in=4'b0000 -> out=2'b00, valid=0 one edge later.
//  - One-hot inputs: in=0001/0010/0100/1000 -> out=00/01/10/11, valid=1, each 1 cycle later.
//  - Priority: in=0011->01, 0110->10, 1010->11, 1111->11, 0101->10, all valid=1.
//  - Exhaustive sweep: in=0..15, one value per cycle.
//    - Each out/valid must match the reference model (index of highest set bit) one cycle later.
//    - Sweep for N=2 and N=3.
//  - Mid-sweep reset: assert rst_n=0 for one edge during the sweep -> that cycle out=0, valid=0.
//    - The next edge resumes correct encoding.

Source files
------------

// File: rtl/problem3.sv
// Registered priority encoder: reports the index of the highest set bit of a
// 2**N-bit request vector, plus a valid flag, one clock after sampling.
module problem3 #(
    parameter int N = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2**N-1:0]  in,
    output logic [N-1:0]     out,
    output logic             valid
);

    localparam int unsigned W = 2**N;

    logic [N-1:0] enc;
    logic         hit;

    // Ascending scan: the last set bit seen wins, so the MSB has top priority.
    always_comb begin
        enc = '0;
        hit = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (in[i]) begin
                enc = N'(i);
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= enc;
            valid <= hit;
        end
    end

endmodule

// File: tb/tb_problem3.sv
// Bench for problem3: directed vectors with literal expectations, plus a
// per-cycle comparison of N=2 and N=3 instances against an arithmetic model.
module tb_problem3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in2 = '0;
    logic [7:0] in3 = '0;
    logic [1:0] out2;
    logic [2:0] out3;
    logic       valid2, valid3;

    int checks = 0;
    int fails  = 0;

    problem3 #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .in(in2), .out(out2), .valid(valid2));
    problem3 #(.N(3)) dut3 (.clk(clk), .rst_n(rst_n), .in(in3), .out(out3), .valid(valid3));

    always #5 clk = ~clk;

    // Highest set bit by arithmetic: floor(log2(x)) == clog2(x+1)-1 for x>0.
    function automatic int unsigned msb_idx(input int unsigned x);
        if (x == 0) return 0;
        return $clog2(x + 1) - 1;
    endfunction

    int unsigned exp_o2, exp_o3;
    logic        exp_v2, exp_v3;
    logic        armed = 1'b0;

    always @(posedge clk) begin
        armed  <= 1'b1;
        exp_o2 <= rst_n ? msb_idx(32'(in2)) : 0;
        exp_v2 <= rst_n ? (in2 != 0) : 1'b0;
        exp_o3 <= rst_n ? msb_idx(32'(in3)) : 0;
        exp_v3 <= rst_n ? (in3 != 0) : 1'b0;
    end

    always @(negedge clk) begin
        if (armed) begin
            checks++;
            if (32'(out2) != exp_o2 || valid2 !== exp_v2) begin
                fails++;
                $display("FAIL model_n2: got out=%0d valid=%b, want out=%0d valid=%b",
                         out2, valid2, exp_o2, exp_v2);
            end
            checks++;
            if (32'(out3) != exp_o3 || valid3 !== exp_v3) begin
                fails++;
                $display("FAIL model_n3: got out=%0d valid=%b, want out=%0d valid=%b",
                         out3, valid3, exp_o3, exp_v3);
            end
        end
    end

    task automatic step(input logic [3:0] v2, input logic [7:0] v3, input logic r);
        in2   = v2;
        in3   = v3;
        rst_n = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step_chk(input logic [3:0] v2, input logic r,
                            input logic [1:0] eo, input logic ev, input string name);
        step(v2, {4'b0000, v2}, r);
        checks++;
        if (out2 !== eo || valid2 !== ev) begin
            fails++;
            $display("FAIL %s: got out=%b valid=%b, want out=%b valid=%b",
                     name, out2, valid2, eo, ev);
        end
    endtask

    initial begin
        @(negedge clk);
        step_chk(4'b1111, 1'b0, 2'b00, 1'b0, "reset_edge1");
        step_chk(4'b1111, 1'b0, 2'b00, 1'b0, "reset_edge2");
        step_chk(4'b0000, 1'b1, 2'b00, 1'b0, "all_zero");
        step_chk(4'b0001, 1'b1, 2'b00, 1'b1, "onehot_0001");
        step_chk(4'b0010, 1'b1, 2'b01, 1'b1, "onehot_0010");
        step_chk(4'b0100, 1'b1, 2'b10, 1'b1, "onehot_0100");
        step_chk(4'b1000, 1'b1, 2'b11, 1'b1, "onehot_1000");
        step_chk(4'b0011, 1'b1, 2'b01, 1'b1, "prio_0011");
        step_chk(4'b0110, 1'b1, 2'b10, 1'b1, "prio_0110");
        step_chk(4'b1010, 1'b1, 2'b11, 1'b1, "prio_1010");
        step_chk(4'b1111, 1'b1, 2'b11, 1'b1, "prio_1111");
        step_chk(4'b0101, 1'b1, 2'b10, 1'b1, "prio_0101");
        step_chk(4'b0000, 1'b1, 2'b00, 1'b0, "zero_after_valid");

        // Exhaustive sweep; N=3 covers all 256 codes, N=2 follows the low nibble.
        for (int v = 0; v < 256; v++) begin
            step(v[3:0], v[7:0], 1'b1);
        end

        // Mid-sweep reset for one edge, then encoding resumes immediately.
        step_chk(4'b0110, 1'b1, 2'b10, 1'b1, "pre_reset");
        step_chk(4'b1100, 1'b0, 2'b00, 1'b0, "mid_reset");
        step_chk(4'b1100, 1'b1, 2'b11, 1'b1, "post_reset");
        step_chk(4'b0001, 1'b1, 2'b00, 1'b1, "post_reset_one");
        for (int v = 15; v >= 0; v--) begin
            step(v[3:0], 8'(v * 16 + v), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
